// File: rtl/mem_stage_pkg.sv
// Shared widths, load-select bit positions, exception indices and bus layouts
// for the LoongArch memory stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 242;
    localparam int MS_TO_WS_BUS_WD = 223;
    localparam int MS_REL_BUS_WD   = 44;
    localparam int EX_GATHER_WD    = 14;

    // One-hot load_sel bit positions
    localparam int LS_W  = 4;
    localparam int LS_H  = 3;
    localparam int LS_HU = 2;
    localparam int LS_B  = 1;
    localparam int LS_BU = 0;

    typedef enum int {
        EX_INT  = 0,
        EX_ADEF = 1,
        EX_TLBR = 2,
        EX_PIF  = 3,
        EX_PPI  = 4,
        EX_SYS  = 5,
        EX_ALE  = 6,
        EX_BRK  = 7,
        EX_INE  = 8,
        EX_PIL  = 9,
        EX_PIS  = 10,
        EX_PME  = 11,
        EX_ADEM = 12,
        EX_IPE  = 13
    } ex_idx_e;

    typedef struct packed {
        logic [31:0]             vaddr;
        logic [4:0]              tlb_op;
        logic [EX_GATHER_WD-1:0] ex_gather;
        logic                    ertn;
        logic [1:0]              csr_op;
        logic [13:0]             csr_rnum;
        logic [31:0]             csr_wmask;
        logic [31:0]             csr_wvalue;
        logic                    mul_horl;
        logic                    mul_op;
        logic [4:0]              load_sel;
        logic [31:0]             sram_rdata;
        logic                    res_from_mem;
        logic                    gr_we;
        logic [4:0]              dest;
        logic [31:0]             alu_result;
        logic [31:0]             pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0]             vaddr;
        logic [4:0]              tlb_op;
        logic [EX_GATHER_WD-1:0] ex_gather;
        logic                    ertn;
        logic [1:0]              csr_op;
        logic [13:0]             csr_rnum;
        logic [31:0]             csr_wmask;
        logic [31:0]             csr_wvalue;
        logic                    gr_we;
        logic [4:0]              dest;
        logic [31:0]             final_result;
        logic [31:0]             pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic [4:0]  tlb_op;
        logic        csr_read_pending;
        logic        fwd_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_rel_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data alignment: picks the addressed byte/half of the
// captured read word and sign/zero-extends it according to the one-hot load_sel.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [4:0]  load_sel_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    assign half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        // NOTE: default assigned first so every path drives data_o and no latch is inferred.
        data_o = rdata_i;
        if (load_sel_i[LS_B]) begin
            data_o = {{24{byte_v[7]}}, byte_v};
        end else if (load_sel_i[LS_BU]) begin
            data_o = {24'd0, byte_v};
        end else if (load_sel_i[LS_H]) begin
            data_o = {{16{half_v[15]}}, half_v};
        end else if (load_sel_i[LS_HU]) begin
            data_o = {16'd0, half_v};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers the execute payload, selects load/mul/ALU result,
// and drives the writeback bus, decode forwarding bus and exception flag.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [63:0]                es_mul_result,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_REL_BUS_WD-1:0]   ms_related_bus,
    input  logic                       ws_ex,
    output logic                       ms_ex
);

    localparam int PAD_WD = MS_TO_WS_BUS_WD - $bits(ms_to_ws_t);

    logic        ms_valid_q;
    logic        ms_valid_d;
    es_to_ms_t   bus_q;
    logic        ms_ready_go;
    logic        has_ex;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_pkt;
    ms_rel_t     rel_pkt;

    // Load data was already returned during execute, so this stage never waits.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ws_ex;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ws_ex) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all clocked state avoids ordering races between flops.
        if (reset) begin
            ms_valid_q <= 1'b0;
        end else begin
            ms_valid_q <= ms_valid_d;
        end
    end

    // NOTE: the payload register carries no reset; ms_valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            bus_q <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    mem_stage_load_align u_load_align (
        .rdata_i    (bus_q.sram_rdata),
        .addr_i     (bus_q.alu_result[1:0]),
        .load_sel_i (bus_q.load_sel),
        .data_o     (load_data)
    );

    always_comb begin
        final_result = bus_q.alu_result;
        if (bus_q.mul_op) begin
            final_result = bus_q.mul_horl ? es_mul_result[63:32] : es_mul_result[31:0];
        end else if (bus_q.res_from_mem) begin
            final_result = load_data;
        end
    end

    assign has_ex = |bus_q.ex_gather;
    assign ms_ex  = ms_valid_q && (has_ex || bus_q.ertn);

    always_comb begin
        ws_pkt.vaddr        = bus_q.vaddr;
        ws_pkt.tlb_op       = bus_q.tlb_op;
        ws_pkt.ex_gather    = bus_q.ex_gather;
        ws_pkt.ertn         = bus_q.ertn;
        ws_pkt.csr_op       = bus_q.csr_op;
        ws_pkt.csr_rnum     = bus_q.csr_rnum;
        ws_pkt.csr_wmask    = bus_q.csr_wmask;
        ws_pkt.csr_wvalue   = bus_q.csr_wvalue;
        ws_pkt.gr_we        = bus_q.gr_we && ms_valid_q && !has_ex;
        ws_pkt.dest         = bus_q.dest;
        ws_pkt.final_result = final_result;
        ws_pkt.pc           = bus_q.pc;
    end

    always_comb begin
        rel_pkt.tlb_op           = bus_q.tlb_op;
        rel_pkt.csr_read_pending = bus_q.csr_op[0];
        rel_pkt.fwd_we           = ms_valid_q && bus_q.gr_we;
        rel_pkt.dest             = bus_q.dest;
        rel_pkt.final_result     = final_result;
    end

    // Packed fields sit at the LSB end; the reserved upper bits are driven zero.
    assign ms_to_ws_bus   = {{PAD_WD{1'b0}}, ws_pkt};
    assign ms_related_bus = rel_pkt;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected writeback
// results; a negedge monitor pops and compares on every accepted transfer.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [241:0] es_to_ms_bus;
    logic [63:0]  es_mul_result;
    logic         ms_to_ws_valid;
    logic [222:0] ms_to_ws_bus;
    logic [43:0]  ms_related_bus;
    logic         ws_ex;
    logic         ms_ex;

    localparam logic [4:0] LW  = 5'b10000;
    localparam logic [4:0] LH  = 5'b01000;
    localparam logic [4:0] LHU = 5'b00100;
    localparam logic [4:0] LB  = 5'b00010;
    localparam logic [4:0] LBU = 5'b00001;
    localparam logic [4:0] NOL = 5'b00000;

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .es_mul_result  (es_mul_result),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_related_bus (ms_related_bus),
        .ws_ex          (ws_ex),
        .ms_ex          (ms_ex)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Builds the execute payload (vaddr mirrors alu_result) and optionally
    // queues the hand-computed writeback expectation; does not advance time.
    task automatic present(input logic [31:0] alu, input logic [4:0] lsel, input logic rfm,
                           input logic mop, input logic horl, input logic [31:0] rdata,
                           input logic [4:0] dest, input logic [13:0] exg, input logic ertn,
                           input logic [1:0] csrop, input logic push, input logic [31:0] exp_res);
        logic [31:0] pc;
        exp_t e;
        pc = 32'h1c00_0000 + (32'(seq) << 2);
        seq++;
        es_to_ms_bus = {alu, 5'd3, exg, ertn, csrop, 14'h0005, 32'hFFFF_0000, 32'h0000_1234,
                        horl, mop, lsel, rdata, rfm, 1'b1, dest, alu, pc};
        es_to_ms_valid = 1'b1;
        if (push) begin
            e.res   = exp_res;
            e.we    = (exg == 14'd0);
            e.dest  = dest;
            e.pc    = pc;
            e.vaddr = alu;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] alu, input logic [4:0] lsel, input logic rfm,
                        input logic mop, input logic horl, input logic [31:0] rdata,
                        input logic [4:0] dest, input logic [31:0] exp_res);
        present(alu, lsel, rfm, mop, horl, rdata, dest, 14'd0, 1'b0, 2'b00, 1'b1, exp_res);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_transfer: got pc %h expected none", ms_to_ws_bus[31:0]);
            end else begin
                e = sb.pop_front();
                check("wb_result", ms_to_ws_bus[63:32], e.res);
                check("wb_gr_we", {31'd0, ms_to_ws_bus[69]}, {31'd0, e.we});
                check("wb_dest", {27'd0, ms_to_ws_bus[68:64]}, {27'd0, e.dest});
                check("wb_pc", ms_to_ws_bus[31:0], e.pc);
                check("wb_vaddr", ms_to_ws_bus[201:170], e.vaddr);
                check("wb_pad", {11'd0, ms_to_ws_bus[222:202]}, 32'd0);
                check("rel_result", ms_related_bus[31:0], e.res);
                check("rel_dest", {27'd0, ms_related_bus[36:32]}, {27'd0, e.dest});
            end
        end
    end

    initial begin
        reset          = 1'b1;
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b0;
        ws_ex          = 1'b0;
        es_to_ms_bus   = '0;
        es_mul_result  = 64'h0000_0001_FFFF_FFFE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("reset_allowin", {31'd0, ms_allowin}, 32'd1);
        check("reset_ms_ex", {31'd0, ms_ex}, 32'd0);
        check("reset_rel_valid", {31'd0, ms_related_bus[37]}, 32'd0);

        // Back-to-back loads, multiplies and an ALU op with ws_allowin=1
        send(32'h0000_1003, LB, 1'b1, 1'b0, 1'b0, 32'h80FF_1234, 5'd5, 32'hFFFF_FF80);
        check("ldb_ws_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("ldb_rel_valid", {31'd0, ms_related_bus[37]}, 32'd1);
        send(32'h0000_1001, LBU, 1'b1, 1'b0, 1'b0, 32'h80FF_1234, 5'd6, 32'h0000_0012);
        send(32'h0000_2002, LHU, 1'b1, 1'b0, 1'b0, 32'hBEEF_0000, 5'd7, 32'h0000_BEEF);
        send(32'h0000_2002, LH, 1'b1, 1'b0, 1'b0, 32'hBEEF_0000, 5'd8, 32'hFFFF_BEEF);
        send(32'h0000_2000, LH, 1'b1, 1'b0, 1'b0, 32'hBEEF_7FFF, 5'd9, 32'h0000_7FFF);
        send(32'h0000_2000, LW, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 5'd10, 32'hCAFE_F00D);
        send(32'h0000_0055, NOL, 1'b0, 1'b1, 1'b1, 32'h0, 5'd11, 32'h0000_0001);
        send(32'h0000_0055, NOL, 1'b0, 1'b1, 1'b0, 32'h0, 5'd12, 32'hFFFF_FFFE);
        send(32'h1234_5678, NOL, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd13, 32'h1234_5678);
        es_to_ms_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drained", 32'(sb.size()), 32'd0);
        check("b2b_idle_valid", {31'd0, ms_to_ws_valid}, 32'd0);

        // Three-cycle writeback stall with the next instruction waiting
        send(32'h0000_000A, NOL, 1'b0, 1'b0, 1'b0, 32'h0, 5'd1, 32'h0000_000A);
        ws_allowin = 1'b0;
        present(32'h0000_000B, NOL, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 14'd0, 1'b0, 2'b00, 1'b1,
                32'h0000_000B);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_allowin", {31'd0, ms_allowin}, 32'd0);
            check("stall_ws_valid", {31'd0, ms_to_ws_valid}, 32'd1);
            check("stall_result", ms_to_ws_bus[63:32], 32'h0000_000A);
            @(posedge clk);
            #1;
        end
        ws_allowin = 1'b1;
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        check("release_next_accepted", ms_to_ws_bus[63:32], 32'h0000_000B);
        check("release_ws_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("release_drained", 32'(sb.size()), 32'd0);

        // Exception resident, then flush from writeback with a new instruction offered
        present(32'h0000_0077, NOL, 1'b0, 1'b0, 1'b0, 32'h0, 5'd7, 14'h0040, 1'b0, 2'b00, 1'b0,
                32'h0);
        @(posedge clk);
        #1;
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b0;
        check("ex_ms_ex", {31'd0, ms_ex}, 32'd1);
        check("ex_gated_we", {31'd0, ms_to_ws_bus[69]}, 32'd0);
        check("ex_rel_valid", {31'd0, ms_related_bus[37]}, 32'd1);
        check("ex_gather_field", {18'd0, ms_to_ws_bus[164:151]}, 32'h0000_0040);
        present(32'h0000_000D, NOL, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 14'd0, 1'b0, 2'b00, 1'b0,
                32'h0);
        ws_ex      = 1'b1;
        ws_allowin = 1'b1;
        #1;
        check("flush_ws_valid_now", {31'd0, ms_to_ws_valid}, 32'd0);
        @(posedge clk);
        #1;
        ws_ex          = 1'b0;
        es_to_ms_valid = 1'b0;
        check("flush_ws_valid_next", {31'd0, ms_to_ws_valid}, 32'd0);
        check("flush_ms_ex", {31'd0, ms_ex}, 32'd0);
        check("flush_rel_valid", {31'd0, ms_related_bus[37]}, 32'd0);

        // CSR read pending plus ertn resident, then reset during a stall
        present(32'h0000_0099, NOL, 1'b0, 1'b0, 1'b0, 32'h0, 5'd9, 14'd0, 1'b1, 2'b01, 1'b0,
                32'h0);
        @(posedge clk);
        #1;
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b0;
        check("csr_pending_bit", {31'd0, ms_related_bus[38]}, 32'd1);
        check("csr_rel_valid", {31'd0, ms_related_bus[37]}, 32'd1);
        check("csr_rel_dest", {27'd0, ms_related_bus[36:32]}, 32'd9);
        check("ertn_ms_ex", {31'd0, ms_ex}, 32'd1);
        @(posedge clk);
        #1;
        check("csr_stall_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midstall_rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("midstall_rst_ms_ex", {31'd0, ms_ex}, 32'd0);
        check("midstall_rst_allowin", {31'd0, ms_allowin}, 32'd1);
        ws_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
